instr_sequencer: RTL and testbench

- Sits directly downstream of the instruction FIFO. Accepts one 64-bit instruction at a time over a valid/ready handshake, decodes it, and sequences the systolic array and its local operand memory.
- Runs each instruction to completion (load weights, load activations, compute plus drain, store results) before accepting the next one.
- Provides busy, halt and illegal-opcode status to the host.

---
 rtl/isa_pkg.sv | 35 +++
 rtl/beat_counter.sv | 34 +++
 rtl/instr_sequencer.sv | 146 ++++++++++++++
 tb/tb_instr_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction sequencer: field positions,
// opcodes, sequencer state encoding and default widths.
package isa_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int LEN_W_DEF     = 12;
    localparam int ARRAY_DIM_DEF = 8;

    localparam int OPC_MSB  = 63;
    localparam int ADDR_MSB = 59;
    localparam int LEN_MSB  = 43;
    localparam int LEN_LSB  = 32;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_LOAD_W = 4'd1;
    localparam logic [3:0] OP_LOAD_A = 4'd2;
    localparam logic [3:0] OP_MATMUL = 4'd3;
    localparam logic [3:0] OP_STORE  = 4'd4;
    localparam logic [3:0] OP_HALT   = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W  = 3'd1,
        ST_LOAD_A  = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_STORE   = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    function automatic logic is_mem_state(input state_e s);
        return (s == ST_LOAD_W) || (s == ST_LOAD_A) || (s == ST_STORE);
    endfunction

endpackage

// File: rtl/beat_counter.sv
// Loadable beat down-counter with a wrapping address incrementer; shared by
// the memory phases and reused to time the compute phase.
module beat_counter #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [LEN_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            count <= '0;
        end else if (load) begin
            addr  <= load_addr;
            count <= load_len;
        end else if (en) begin
            addr  <= addr + ADDR_W'(1);
            count <= count - LEN_W'(1);
        end
    end

    assign last = (count == LEN_W'(1));

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts one instruction at a time, decodes it and
// drives operand-memory beats, array strobes and host status.
module instr_sequencer
    import isa_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int ARRAY_DIM = ARRAY_DIM_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    output logic              array_load_w,
    output logic              array_load_a,
    output logic              array_compute,
    output logic              busy,
    output logic              halted,
    output logic              illegal_op
);

    localparam int DRAIN_W = $clog2(2 * ARRAY_DIM);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * ARRAY_DIM - 2);

    state_e              state;
    logic [3:0]          cur_op;
    logic [DRAIN_W-1:0]  drain_cnt;

    logic [3:0]          opcode;
    logic [ADDR_W-1:0]   f_addr;
    logic [LEN_W-1:0]    f_len;
    logic                len_nz;
    logic                accept;
    logic                granted;
    logic                cnt_en;
    logic                cnt_last;
    logic                reserved_unused;

    assign opcode          = instr_in[OPC_MSB -: 4];
    assign f_addr          = instr_in[ADDR_MSB -: ADDR_W];
    assign f_len           = instr_in[LEN_MSB -: LEN_W];
    assign reserved_unused = ^instr_in[LEN_LSB-1:0];
    assign len_nz          = (f_len != '0);

    assign instr_ready = (state == ST_IDLE) && !halted;
    assign busy        = (state != ST_IDLE);
    assign accept      = instr_valid && instr_ready;
    assign granted     = is_mem_state(state) && mem_gnt;
    // The compute phase reuses the beat counter as its cycle timer.
    assign cnt_en      = granted || (state == ST_COMPUTE);

    beat_counter #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_beat_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .en        (cnt_en),
        .load_addr (f_addr),
        .load_len  (f_len),
        .addr      (mem_addr),
        .last      (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cur_op        <= OP_NOP;
            drain_cnt     <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            array_load_w  <= 1'b0;
            array_load_a  <= 1'b0;
            array_compute <= 1'b0;
            halted        <= 1'b0;
            illegal_op    <= 1'b0;
        end else begin
            // Read data arrives one cycle after the grant, so the strobes lag.
            array_load_w <= granted && (cur_op == OP_LOAD_W);
            array_load_a <= granted && (cur_op == OP_LOAD_A);
            illegal_op   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur_op <= opcode;
                        case (opcode)
                            OP_NOP: begin end
                            OP_LOAD_W: if (len_nz) begin
                                state   <= ST_LOAD_W;
                                mem_req <= 1'b1;
                            end
                            OP_LOAD_A: if (len_nz) begin
                                state   <= ST_LOAD_A;
                                mem_req <= 1'b1;
                            end
                            OP_STORE: if (len_nz) begin
                                state   <= ST_STORE;
                                mem_req <= 1'b1;
                                mem_we  <= 1'b1;
                            end
                            OP_MATMUL: if (len_nz) begin
                                state         <= ST_COMPUTE;
                                array_compute <= 1'b1;
                            end
                            OP_HALT: begin
                                state  <= ST_HALT;
                                halted <= 1'b1;
                            end
                            default: illegal_op <= 1'b1;
                        endcase
                    end
                end
                ST_LOAD_W, ST_LOAD_A, ST_STORE: begin
                    if (mem_gnt && cnt_last) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                ST_COMPUTE: begin
                    if (cnt_last) begin
                        state         <= ST_DRAIN;
                        array_compute <= 1'b0;
                        drain_cnt     <= DRAIN_LAST;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                ST_HALT: begin end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a transaction-level model expands
// each instruction into a per-cycle plan of drives and expected outputs.
module tb_instr_sequencer;

    localparam int ADDR_W    = 16;
    localparam int LEN_W     = 12;
    localparam int ARRAY_DIM = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [63:0]       instr_in = '0;
    logic              instr_valid = 1'b0;
    logic              mem_gnt = 1'b0;
    logic              instr_ready, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              array_load_w, array_load_a, array_compute;
    logic              busy, halted, illegal_op;

    always #5 clk = ~clk;

    instr_sequencer #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .ARRAY_DIM (ARRAY_DIM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_in      (instr_in),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .array_load_w  (array_load_w),
        .array_load_a  (array_load_a),
        .array_compute (array_compute),
        .busy          (busy),
        .halted        (halted),
        .illegal_op    (illegal_op)
    );

    typedef struct packed {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic        lw;
        logic        la;
        logic        comp;
        logic        busy;
        logic        halted;
        logic        illegal;
        logic        ready;
    } obs_t;

    typedef struct {
        logic        vld;
        logic [63:0] ins;
        logic        gnt;
        obs_t        exp;
    } step_t;

    step_t plan[$];
    int    checks = 0;
    int    errors = 0;
    logic  carry_w = 1'b0;
    logic  carry_a = 1'b0;
    logic  carry_ill = 1'b0;

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [15:0] a, input logic [11:0] l);
        return {op, a, l, 32'($urandom)};
    endfunction

    function automatic logic [63:0] junk();
        return {32'($urandom), 32'($urandom)};
    endfunction

    function automatic void resetModel();
        carry_w   = 1'b0;
        carry_a   = 1'b0;
        carry_ill = 1'b0;
    endfunction

    // An idle cycle shows whatever the previous instruction left trailing.
    function automatic obs_t quiet();
        obs_t o;
        o         = '0;
        o.ready   = 1'b1;
        o.lw      = carry_w;
        o.la      = carry_a;
        o.illegal = carry_ill;
        resetModel();
        return o;
    endfunction

    function automatic void push(input logic vld, input logic [63:0] ins, input logic gnt, input obs_t e);
        step_t s;
        s.vld = vld;
        s.ins = ins;
        s.gnt = gnt;
        s.exp = e;
        plan.push_back(s);
    endfunction

    // gmode: 0 random grants, 1 always granted, 2 alternating starting with a grant
    function automatic void addInstr(input logic [63:0] ins, input int gmode);
        logic [3:0]  op = ins[63:60];
        logic [15:0] a = ins[59:44];
        int          left = int'(ins[43:32]);
        logic        strobe = 1'b0;
        logic        g;
        int          stalls = 0;
        int          k = 0;
        obs_t        e;
        push(1'b1, ins, 1'($urandom_range(0, 1)), quiet());
        if ((op == 4'd1 || op == 4'd2 || op == 4'd4) && left > 0) begin
            while (left > 0) begin
                e      = '0;
                e.req  = 1'b1;
                e.we   = (op == 4'd4);
                e.addr = a;
                e.lw   = strobe && (op == 4'd1);
                e.la   = strobe && (op == 4'd2);
                e.busy = 1'b1;
                if (gmode == 1) g = 1'b1;
                else if (gmode == 2) g = (k % 2 == 0);
                else g = ($urandom_range(0, 2) != 0) || (stalls >= 3);
                push(1'b0, junk(), g, e);
                strobe = g;
                k++;
                if (g) begin
                    a = a + 16'd1;
                    left--;
                    stalls = 0;
                end else begin
                    stalls++;
                end
            end
            carry_w = (op == 4'd1);
            carry_a = (op == 4'd2);
        end else if (op == 4'd3 && left > 0) begin
            for (int i = 0; i < left + 2 * ARRAY_DIM - 1; i++) begin
                e      = '0;
                e.comp = (i < left);
                e.busy = 1'b1;
                push(1'b0, junk(), 1'($urandom_range(0, 1)), e);
            end
        end else if (op > 4'd4 && op != 4'd15) begin
            carry_ill = 1'b1;
        end
    endfunction

    function automatic void flush(input int n);
        for (int i = 0; i < n; i++) push(1'b0, junk(), 1'b0, quiet());
    endfunction

    task automatic checkOutput(input string tag, input int idx, input obs_t exp, input bit ignore_ready);
        obs_t o;
        o = {mem_req, mem_we, mem_addr, array_load_w, array_load_a, array_compute,
             busy, halted, illegal_op, instr_ready};
        if (!exp.req) o.addr = '0;
        if (ignore_ready) o.ready = 1'b0;
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("[TB] FAIL %s step %0d: observed %h expected %h", tag, idx, o, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input int limit);
        for (int i = 0; i < plan.size() && (limit < 0 || i < limit); i++) begin
            instr_valid = plan[i].vld;
            instr_in    = plan[i].ins;
            mem_gnt     = plan[i].gnt;
            @(negedge clk);
            checkOutput(tag, i, plan[i].exp, 1'b0);
            @(posedge clk);
            #1;
        end
        plan.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] ins;
        logic [3:0]  op;
        int          r;
        obs_t        zero;
        obs_t        hold;
        zero = '0;

        #12;
        checkOutput("reset_values", 0, zero, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        flush(1);
        applyStimulus("after_reset", -1);

        addInstr(mk(4'd1, 16'h0010, 12'd4), 1);
        flush(2);
        applyStimulus("load_w_basic", -1);

        addInstr(mk(4'd4, 16'hFFFE, 12'd4), 2);
        flush(1);
        applyStimulus("store_wrap_stall", -1);

        addInstr(mk(4'd3, 16'h1234, 12'd5), 0);
        flush(1);
        applyStimulus("matmul_drain", -1);

        addInstr(mk(4'd7, 16'h0000, 12'd3), 0);
        addInstr(mk(4'd0, 16'h0000, 12'd0), 0);
        addInstr(mk(4'd2, 16'h0040, 12'd0), 0);
        flush(2);
        applyStimulus("illegal_nop_len0", -1);

        for (int i = 0; i < 6; i++) addInstr(mk(4'd0, 16'($urandom), 12'($urandom)), 0);
        flush(1);
        applyStimulus("nop_stream", -1);

        addInstr(mk(4'd4, 16'hFFFF, 12'd1), 0);
        addInstr(mk(4'd3, 16'h0000, 12'd1), 0);
        addInstr(mk(4'd3, 16'h0000, 12'd0), 0);
        flush(1);
        applyStimulus("len_one_edges", -1);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 6);
            if (r <= 4) op = 4'(r);
            else op = 4'($urandom_range(5, 14));
            if (op == 4'd3) ins = mk(op, 16'($urandom), 12'($urandom_range(0, 6)));
            else ins = mk(op, 16'($urandom), 12'($urandom_range(0, 10)));
            addInstr(ins, 0);
        end
        flush(2);
        applyStimulus("random_stream", -1);

        addInstr(mk(4'd1, 16'h0200, 12'd8), 1);
        applyStimulus("reset_mid_load", 3);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_load_async", 0, zero, 1'b1);
        #1;
        rst_n = 1'b1;
        resetModel();
        flush(5);
        applyStimulus("reset_mid_load_after", -1);

        ins = mk(4'd1, 16'h0300, 12'd3);
        push(1'b1, mk(4'd15, 16'h0000, 12'd0), 1'b1, quiet());
        hold        = '0;
        hold.busy   = 1'b1;
        hold.halted = 1'b1;
        for (int i = 0; i < 6; i++) push(1'b1, ins, 1'b1, hold);
        applyStimulus("halt_hold", -1);
        rst_n = 1'b0;
        #1;
        checkOutput("halt_reset_async", 0, zero, 1'b1);
        #1;
        rst_n = 1'b1;
        resetModel();
        addInstr(ins, 1);
        flush(2);
        applyStimulus("after_halt_load_w", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
